// File: rtl/rca_seq_ctrl.sv
// Byte-serial add/subtract sequencer driving an external 8-bit ripple-carry adder.
// Operands are sliced LSB-first, the carry is chained across slices, and the result returns via valid/ready.
module rca_seq_ctrl #(
  parameter int NBYTES = 4,
  parameter int IDXW   = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [8*NBYTES-1:0]   in_a,
  input  logic [8*NBYTES-1:0]   in_b,
  input  logic                  in_cin,
  input  logic                  in_sub,
  output logic [7:0]            add_a,
  output logic [7:0]            add_b,
  output logic                  add_cin,
  input  logic [7:0]            add_sum,
  input  logic                  add_cout,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [8*NBYTES-1:0]   res_sum,
  output logic                  res_cout,
  output logic                  res_ovf,
  output logic                  busy
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t              state, state_nx;
  logic [IDXW-1:0]     idx;
  logic                carry;
  logic [8*NBYTES-1:0] a_reg, b_reg;
  logic                accept;
  logic                last;

  assign accept = in_valid && in_ready;
  assign last   = (idx == IDXW'(NBYTES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // NOTE: every output of this block gets a default first, so no path leaves a
  // signal unassigned and no latch is inferred.
  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    res_valid = 1'b0;
    busy      = 1'b1;
    add_a     = '0;
    add_b     = '0;
    add_cin   = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) state_nx = RUN;
      end
      RUN: begin
        add_a   = a_reg[8*idx +: 8];
        add_b   = b_reg[8*idx +: 8];
        add_cin = carry;
        if (last) state_nx = DONE;
      end
      DONE: begin
        res_valid = 1'b1;
        if (res_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  // NOTE: the operand and result registers are reset as well; an aborted
  // operation must leave no stale bytes visible on res_sum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx      <= '0;
      carry    <= 1'b0;
      a_reg    <= '0;
      b_reg    <= '0;
      res_sum  <= '0;
      res_cout <= 1'b0;
      res_ovf  <= 1'b0;
    end else begin
      if (accept) begin
        a_reg <= in_a;
        b_reg <= in_sub ? ~in_b : in_b;
        carry <= in_sub ? 1'b1 : in_cin;
        idx   <= '0;
      end else if (state == RUN) begin
        res_sum[8*idx +: 8] <= add_sum;
        carry               <= add_cout;
        idx                 <= idx + 1'b1;
        if (last) begin
          res_cout <= add_cout;
          // Overflow: like-signed operands (B after inversion) producing an opposite-signed sum.
          res_ovf  <= (a_reg[8*NBYTES-1] == b_reg[8*NBYTES-1]) &&
                      (add_sum[7] != a_reg[8*NBYTES-1]);
        end
      end
    end
  end

endmodule
